// File: rtl/boss_seq.sv
// boss_seq: boss-pose sequencer for the dance game.
// Owns the beat timer, the boss pose FSM (fixed cycle or LFSR-random),
// per-beat judging, BCD scoring, miss counting and the boss sprite rows.
//
// Player input handshake: player_valid is a one-cycle strobe that qualifies
// player_pose on the same edge. There is no ready/back-pressure; the block is
// always ready. A strobe is consumed on the edge where it is high. Only the
// first strobe of a beat is judged; later strobes in that beat and strobes
// outside PLAY are dropped.
module boss_seq #(
    parameter int         BEAT_CYCLES = 100000,
    parameter int         MAX_MISS    = 3,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mode,
    input  logic [1:0] player_pose,
    input  logic       player_valid,
    input  logic [2:0] row_count,
    output logic [7:0] dot_col,
    output logic [1:0] cur_state,
    output logic       beat,
    output logic       hit,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic [1:0] misses,
    output logic       game_over,
    output logic [1:0] dbg_state
);

    localparam int             CW   = $clog2(BEAT_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(BEAT_CYCLES - 1);
    localparam logic [7:0]     SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [1:0]     MAXM = 2'(MAX_MISS);

    localparam logic [1:0] P_UP      = 2'b11;
    localparam logic [1:0] P_DOWN    = 2'b00;
    localparam logic [1:0] P_LEFTUP  = 2'b10;
    localparam logic [1:0] P_RIGHTUP = 2'b01;

    // Debug encoding on dbg_state: 0 = IDLE, 1 = PLAY, 2 = OVER.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] beat_cnt;
    logic [7:0]    lfsr;
    logic          judged;
    logic          got;

    logic          wrap;
    logic          judge_now;
    logic          correct;
    logic          miss_now;
    logic [1:0]    misses_nxt;
    logic [7:0]    lfsr_nxt;
    logic [1:0]    next_pose;
    logic [1:0]    cand;
    logic [3:0]    ones_nxt;
    logic [3:0]    tens_nxt;
    logic [7:0]    row_data;

    assign dbg_state = state;

    // Beat boundary, judging decision, miss accounting and LFSR step.
    always_comb begin
        wrap       = (state == S_PLAY) && (beat_cnt == LAST);
        judge_now  = (state == S_PLAY) && player_valid && !judged;
        correct    = judge_now && (player_pose == cur_state);
        miss_now   = !(got || correct);
        misses_nxt = misses + {1'b0, miss_now};
        lfsr_nxt   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Next boss pose: fixed rotation, or LFSR candidate forced to differ.
    always_comb begin
        cand      = lfsr_nxt[1:0];
        next_pose = cur_state;
        if (mode) begin
            next_pose = (cand == cur_state) ? cur_state + 2'd1 : cand;
        end else begin
            case (cur_state)
                P_RIGHTUP: next_pose = P_UP;
                P_UP:      next_pose = P_DOWN;
                P_DOWN:    next_pose = P_LEFTUP;
                default:   next_pose = P_RIGHTUP;
            endcase
        end
    end

    // BCD increment of the score, 99 wraps to 00.
    always_comb begin
        ones_nxt = score_ones + 4'd1;
        tens_nxt = score_tens;
        if (score_ones == 4'd9) begin
            ones_nxt = 4'd0;
            tens_nxt = (score_tens == 4'd9) ? 4'd0 : score_tens + 4'd1;
        end
    end

    // Sprite row lookup for the scanned row and current pose.
    always_comb begin
        row_data = 8'b0000_0000;
        case (row_count)
            3'd0: row_data = 8'b0000_0000;
            3'd3: row_data = 8'b1111_1111;
            3'd6, 3'd7: row_data = 8'b0010_0100;
            3'd1, 3'd2: begin
                case (cur_state)
                    P_UP:     row_data = 8'b1001_1001;
                    P_DOWN:   row_data = 8'b0001_1000;
                    P_LEFTUP: row_data = 8'b1001_1000;
                    default:  row_data = 8'b0001_1001;
                endcase
            end
            3'd4: begin
                case (cur_state)
                    P_UP:     row_data = 8'b0001_1000;
                    P_DOWN:   row_data = 8'b1001_1001;
                    P_LEFTUP: row_data = 8'b0001_1001;
                    default:  row_data = 8'b1001_1000;
                endcase
            end
            default: begin
                case (cur_state)
                    P_UP:     row_data = 8'b0011_1100;
                    P_DOWN:   row_data = 8'b1011_1101;
                    P_LEFTUP: row_data = 8'b0011_1101;
                    default:  row_data = 8'b1011_1100;
                endcase
            end
        endcase
    end

    // Game FSM with beat timer, judging, scoring and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            beat_cnt   <= '0;
            lfsr       <= SEED;
            judged     <= 1'b0;
            got        <= 1'b0;
            cur_state  <= P_RIGHTUP;
            dot_col    <= 8'h00;
            beat       <= 1'b0;
            hit        <= 1'b0;
            score_ones <= 4'd0;
            score_tens <= 4'd0;
            misses     <= 2'd0;
            game_over  <= 1'b0;
        end else begin
            beat    <= 1'b0;
            hit     <= 1'b0;
            dot_col <= row_data;
            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state      <= S_PLAY;
                        game_over  <= 1'b0;
                        score_ones <= 4'd0;
                        score_tens <= 4'd0;
                        misses     <= 2'd0;
                        judged     <= 1'b0;
                        got        <= 1'b0;
                        beat_cnt   <= '0;
                    end
                end
                S_PLAY: begin
                    if (correct) begin
                        hit        <= 1'b1;
                        score_ones <= ones_nxt;
                        score_tens <= tens_nxt;
                    end
                    if (wrap) begin
                        // A strobe on the wrap edge was judged above against
                        // the outgoing pose; the new beat starts unjudged.
                        beat     <= 1'b1;
                        beat_cnt <= '0;
                        judged   <= 1'b0;
                        got      <= 1'b0;
                        lfsr     <= lfsr_nxt;
                        misses   <= misses_nxt;
                        if (misses_nxt == MAXM) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                        end else begin
                            cur_state <= next_pose;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if (judge_now) begin
                            judged <= 1'b1;
                            if (correct) begin
                                got <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boss_seq.sv
// tb_boss_seq: randomized and directed bench for boss_seq with a
// game-level reference model (integer score, miss count, pose table).
module tb_boss_seq;

    localparam int B  = 8;
    localparam int MM = 3;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] player_pose = 2'b00;
    logic       player_valid = 1'b0;
    logic [2:0] row_count = 3'd0;
    logic [7:0] dot_col;
    logic [1:0] cur_state;
    logic       beat;
    logic       hit;
    logic [3:0] score_ones;
    logic [3:0] score_tens;
    logic [1:0] misses;
    logic       game_over;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    boss_seq #(.BEAT_CYCLES(B), .MAX_MISS(MM), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .player_pose(player_pose), .player_valid(player_valid),
        .row_count(row_count), .dot_col(dot_col), .cur_state(cur_state),
        .beat(beat), .hit(hit), .score_ones(score_ones),
        .score_tens(score_tens), .misses(misses), .game_over(game_over),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 play, 2 over. Poses use the output encoding.
    int   m_phase, m_cnt, m_score, m_miss, m_pose, m_lfsr;
    bit   m_judged, m_got, m_beat, m_hit;
    logic [7:0] m_dot;

    function automatic logic [7:0] sprite(input int pose, input int row);
        logic [7:0] r12 [4];
        logic [7:0] r4  [4];
        logic [7:0] r5  [4];
        // indexed by pose code: 0 DOWN, 1 RIGHTUP, 2 LEFTUP, 3 UP
        r12 = '{8'b00011000, 8'b00011001, 8'b10011000, 8'b10011001};
        r4  = '{8'b10011001, 8'b10011000, 8'b00011001, 8'b00011000};
        r5  = '{8'b10111101, 8'b10111100, 8'b00111101, 8'b00111100};
        if (row == 0) return 8'h00;
        if (row == 1 || row == 2) return r12[pose];
        if (row == 3) return 8'hFF;
        if (row == 4) return r4[pose];
        if (row == 5) return r5[pose];
        return 8'b00100100;
    endfunction

    function automatic int fixed_next(input int pose);
        int order [4];
        order = '{1, 3, 0, 2};   // RIGHTUP, UP, DOWN, LEFTUP
        for (int i = 0; i < 4; i++)
            if (order[i] == pose) return order[(i + 1) % 4];
        return 1;
    endfunction

    function automatic int lfsr_shift(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) & 255) | fb;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_score = 0; m_miss = 0; m_pose = 1;
        m_lfsr = 'hA5; m_judged = 0; m_got = 0; m_beat = 0; m_hit = 0;
        m_dot = 8'h00;
    endtask

    task automatic model_step();
        bit jn, ok;
        int c;
        m_beat = 0;
        m_hit  = 0;
        m_dot  = sprite(m_pose, int'(row_count));
        if (m_phase != 1) begin
            if (start) begin
                m_phase = 1; m_score = 0; m_miss = 0;
                m_judged = 0; m_got = 0; m_cnt = 0;
            end
        end else begin
            jn = player_valid && !m_judged;
            ok = jn && (int'(player_pose) == m_pose);
            if (ok) begin
                m_hit = 1;
                m_score = (m_score + 1) % 100;
            end
            if (jn) m_judged = 1;
            if (ok) m_got = 1;
            if (m_cnt == B - 1) begin
                m_beat = 1;
                m_cnt  = 0;
                if (!m_got) m_miss++;
                m_lfsr = lfsr_shift(m_lfsr);
                if (m_miss == MM) begin
                    m_phase = 2;
                end else if (mode) begin
                    c = m_lfsr & 3;
                    m_pose = (c == m_pose) ? (m_pose + 1) % 4 : c;
                end else begin
                    m_pose = fixed_next(m_pose);
                end
                m_judged = 0;
                m_got    = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    // ---------------- scoreboard compare (every cycle) ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("dot_col",    32'(dot_col),    32'(m_dot));
            chk("cur_state",  32'(cur_state),  32'(m_pose));
            chk("beat",       32'(beat),       32'(m_beat));
            chk("hit",        32'(hit),        32'(m_hit));
            chk("score_tens", 32'(score_tens), 32'(m_score / 10));
            chk("score_ones", 32'(score_ones), 32'(m_score % 10));
            chk("misses",     32'(misses),     32'(m_miss));
            chk("game_over",  32'(game_over),  32'(m_phase == 2));
            chk("dbg_state",  32'(dbg_state),  32'(m_phase));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic strobe(input int pose);
        player_pose  = 2'(pose);
        player_valid = 1'b1;
        tick();
        player_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int c);
        int n;
        n = 0;
        while (m_cnt != c && n < 4 * B) begin
            tick();
            n++;
        end
        if (m_cnt != c) begin
            n_checks++;
            $display("FAIL wait_cnt: timeout waiting for count %0d (at %0d)", c, m_cnt);
        end
    endtask

    task automatic wait_beat();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_beat && n < 4 * B);
        if (!m_beat) begin
            n_checks++;
            $display("FAIL wait_beat: no beat within %0d cycles", 4 * B);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [1:0] prev_pose;

    initial begin
        reset = 1'b1;
        #3 reset = 1'b0;
        check_en = 1'b1;
        repeat (2) tick();
        #2 reset = 1'b1;

        // 1: sprite rows after reset, one cycle late
        for (int r = 0; r < 8; r++) begin
            row_count = 3'(r);
            tick();
            if (r == 1) chk("row1_lit", 32'(dot_col), 32'(8'b00011001));
            if (r == 4) chk("row4_lit", 32'(dot_col), 32'(8'b10011000));
        end

        // 2: fixed mode, two idle beats
        mode = 1'b0;
        pulse_start();
        repeat (2 * B) tick();
        chk("two_miss_lit", 32'(misses), 32'd2);
        chk("pose_down_lit", 32'(cur_state), 32'(2'b00));

        // 3: twelve correct beats, double strobe each
        for (int i = 0; i < 12; i++) begin
            wait_cnt(2);
            strobe(m_pose);
            strobe(m_pose);
            wait_cnt(0);
        end
        chk("tens12_lit", 32'(score_tens), 32'd1);
        chk("ones12_lit", 32'(score_ones), 32'd2);

        // 4: wrong then right in one beat -> third miss ends the game
        wait_cnt(2);
        strobe((m_pose + 1) % 4);
        strobe(m_pose);
        wait_cnt(0);
        chk("lockout_miss_lit", 32'(misses), 32'd3);
        chk("over_lit", 32'(game_over), 32'd1);

        // 5: strobe on the wrap cycle, then judge the new beat
        pulse_start();
        wait_cnt(B - 1);
        strobe(m_pose);
        chk("wrap_hit_lit", 32'(hit), 32'd1);
        wait_cnt(3);
        strobe(m_pose);
        chk("newbeat_hit_lit", 32'(hit), 32'd1);
        chk("score2_lit", 32'(score_ones), 32'd2);
        wait_cnt(0);

        // 6: LFSR mode, three idle beats -> game over, pose frozen
        mode = 1'b1;
        prev_pose = cur_state;
        for (int i = 0; i < 3; i++) begin
            wait_beat();
            if (i < 2) begin
                n_checks++;
                if (cur_state !== prev_pose) n_pass++;
                else $display("FAIL pose_repeat: got %0b expected not %0b", cur_state, prev_pose);
            end
            prev_pose = cur_state;
        end
        chk("lfsr_over_lit", 32'(game_over), 32'd1);
        repeat (2 * B) tick();
        chk("frozen_pose", 32'(cur_state), 32'(prev_pose));
        pulse_start();
        chk("restart_score", 32'(score_ones), 32'd0);
        chk("restart_miss", 32'(misses), 32'd0);

        // mid-game asynchronous reset
        repeat (5) tick();
        #2 reset = 1'b0;
        #1 chk("async_pose", 32'(cur_state), 32'(2'b01));
        chk("async_state", 32'(dbg_state), 32'd0);
        tick();
        #2 reset = 1'b1;

        // randomized play
        repeat (3000) begin
            row_count    = 3'($urandom_range(0, 7));
            player_valid = ($urandom_range(0, 3) == 0);
            player_pose  = ($urandom_range(0, 1) == 1) ? 2'(m_pose) : 2'($urandom_range(0, 3));
            start        = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            if ($urandom_range(0, 999) == 0) begin
                #1 reset = 1'b0;
                #2 reset = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        player_valid = 1'b0;
        tick();
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/boss_seq.md
# boss_seq

Parametrised boss-pose sequencer for the dance game. Owns the beat timer, the boss pose FSM (fixed cycle or LFSR-random), per-beat judging of the player's pose, BCD scoring, miss counting with game-over, and the registered 8x8 dot-matrix row data for the boss sprite. It sits between the matrix row scanner (`row_count`) and the player-input decoder (`player_pose`/`player_valid`), and drives the seven-segment decoders with BCD score digits.

## Interface

Parameters:
- `BEAT_CYCLES`, default 100000: clk cycles per beat (pose period); must be ≥ 4.
- `MAX_MISS`, default 3: misses that end the game; range 1..3.
- `LFSR_SEED`, default 8'hA5: LFSR reset value; 8'h00 is loaded as 8'h01.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; IDLE/OVER → PLAY.
- `mode` in 1: 0 = fixed pose cycle, 1 = LFSR-random; sampled at every beat.
- `player_pose` in 2: player pose, same encoding as `cur_state`.
- `player_valid` in 1: one-cycle strobe qualifying `player_pose`.
- `row_count` in 3: row currently scanned by the matrix driver.
- `dot_col` out 8: column data for `row_count`, registered.
- `cur_state` out 2: boss pose; UP=2'b11, DOWN=2'b00, LEFTUP=2'b10, RIGHTUP=2'b01.
- `beat` out 1: one-cycle pulse on each beat boundary in PLAY.
- `hit` out 1: one-cycle pulse on a correct judge.
- `score_ones`, `score_tens` out 4 each: BCD score, 00..99.
- `misses` out 2: misses this game.
- `game_over` out 1: high in OVER.

## Operation

- FSM states: IDLE, PLAY, OVER. Reset → IDLE.
- IDLE: beat counter held at 0; pose holds; `start` → PLAY and clears score, misses, the judged flag, and the beat counter.
- PLAY:
  - Beat counter runs 0..BEAT_CYCLES-1. At the wrap, `beat` pulses and the pose advances.
  - The ending beat is then judged: if no correct hit occurred during it, `misses` increments.
  - If `misses` reaches MAX_MISS at that wrap, go to OVER. The pose does not advance on that wrap.
- OVER: `game_over`=1; pose, score, and misses are frozen; `start` → PLAY with clears as above.
- Judging, at most once per beat:
  - The first `player_valid` in a beat sets the judged flag.
  - If `player_pose == cur_state`, `hit` pulses and the score increments. 09→10; 99→00 wraps.
  - If the pose is wrong, the flag is set with no score (lock-out), and the beat counts as a miss at its end.
  - Further strobes that beat are ignored. The flag clears at each wrap.
  - Strobes outside PLAY are ignored.
- Simultaneous `player_valid` and wrap: judged against the outgoing pose and counted for the ending beat. The new beat starts unjudged.
- Fixed mode: RIGHTUP → UP → DOWN → LEFTUP → RIGHTUP.
- LFSR mode:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shifts once per wrap in PLAY.
  - Candidate pose = new `lfsr[1:0]`. If the candidate equals `cur_state`, use `cur_state+1` mod 4, so the pose always changes.
- `dot_col` bitmaps, rows 0..7. All poses share rows 0=00000000, 3=11111111, 6=00100100, 7=00100100. Per pose, rows 1 and 2 are identical:
  - UP: r1/r2 10011001, r4 00011000, r5 00111100.
  - DOWN: r1/r2 00011000, r4 10011001, r5 10111101.
  - LEFTUP: r1/r2 10011000, r4 00011001, r5 00111101.
  - RIGHTUP: r1/r2 00011001, r4 10011000, r5 10111100.

## Timing

- Reset values (async assert, synchronous-safe release):
  - `dot_col`=0, `cur_state`=RIGHTUP, `beat`=0, `hit`=0.
  - Score=00, `misses`=0, `game_over`=0.
  - LFSR=seed, FSM=IDLE.
- `start` at edge k: PLAY from k+1. The first `beat` pulse occurs at edge k+BEAT_CYCLES, and `cur_state` changes on that same edge.
- `hit` and the score update occur one cycle after the `player_valid` edge.
- The `misses` update and the OVER transition occur on the wrap edge; `game_over` is visible the following cycle.
- `dot_col` reflects the `row_count` and `cur_state` sampled at the previous edge (1-cycle latency).
- Reset asserted mid-game aborts immediately to the reset values.

## Test plan

Bench parameters: BEAT_CYCLES=8, MAX_MISS=3.

1. Reset, then drive `row_count` 0..7 → `dot_col` = RIGHTUP rows, one cycle late. Row 1=00011001, row 4=10011000.
2. `mode`=0, `start`, no input for 2 beats → `cur_state` goes 01 → 11 → 00 with `beat` pulses 8 cycles apart; `misses`=2.
3. Per beat, `player_valid` with the correct pose, 12 beats → `hit` pulses ×12; score 12 (`score_tens`=1, `score_ones`=2). A second correct strobe in the same beat adds nothing.
4. Wrong pose, then correct pose in the same beat → no `hit`, miss counted at the wrap.
5. `player_valid` on the wrap cycle with the outgoing pose → `hit`; the new beat is still judgeable.
6. `mode`=1, no input for 3 beats → three consecutive beats never repeat a pose; `game_over`=1 after the third wrap and the pose freezes. `start` → score and `misses` return to 0.
